fir_tap_sequencer: RTL

- Time-multiplexed FIR controller that sits directly upstream of the MAC16 DSP block.
- Accepts one signed audio sample per handshake and stores it in a circular delay line.
- Streams NTAPS sample/coefficient operand pairs into the MAC, then captures its 32-bit accumulator output.
- Rounds and saturates that output to 16 bits and presents it on a valid/ready output port.

---
 rtl/fir_tap_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR controller feeding an external MAC: keeps a circular delay line, streams
// sample/coefficient pairs into the MAC, then rounds and saturates the accumulator to 16 bits.
module fir_tap_sequencer #(
  parameter int unsigned NTAPS     = 16,
  parameter int unsigned MAC_LAT   = 1,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [15:0]       s_data,
  input  logic                     coef_wr_en,
  input  logic [$clog2(NTAPS)-1:0] coef_wr_addr,
  input  logic signed [15:0]       coef_wr_data,
  output logic signed [15:0]       mac_a,
  output logic signed [15:0]       mac_b,
  output logic                     mac_load,
  output logic                     mac_ce,
  input  logic signed [31:0]       mac_o,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [15:0]       m_data,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(NTAPS);
  localparam int unsigned DW = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic signed [32:0] RND = 33'sd1 <<< (OUT_SHIFT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]        k_q;
  logic [AW-1:0]        wptr_q;
  logic [AW-1:0]        rd_idx;
  logic [DW-1:0]        drain_q;
  logic signed [15:0]   delay_q [NTAPS];
  logic signed [15:0]   coef_q  [NTAPS];
  logic signed [15:0]   mac_a_q, mac_b_q;
  logic                 mac_load_q, mac_ce_q;
  logic                 m_valid_q;
  logic signed [15:0]   m_data_q;
  logic                 accept;
  logic signed [32:0]   mac_ext, q_sum, q_shift;
  logic signed [15:0]   quant;

  assign busy     = (state_q != StIdle);
  // Held low for the whole reset pulse, not just once the state register settles.
  assign s_ready  = (state_q == StIdle) && !rst;
  assign accept   = s_valid && s_ready;
  assign rd_idx   = wptr_q - k_q;

  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_load = mac_load_q;
  assign mac_ce   = mac_ce_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;

  // Round half up, then clamp to the signed 16-bit range.
  always_comb begin
    mac_ext = {mac_o[31], mac_o};
    q_sum   = mac_ext + RND;
    q_shift = q_sum >>> OUT_SHIFT;
    if (q_shift > 33'sd32767) begin
      quant = 16'sh7fff;
    end else if (q_shift < -33'sd32768) begin
      quant = 16'sh8000;
    end else begin
      quant = q_shift[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (k_q == AW'(NTAPS - 1)) state_d = StDrain;
      StDrain: if (drain_q == DW'(MAC_LAT)) state_d = StOut;
      StOut:   if (m_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q        <= '0;
      wptr_q     <= '0;
      drain_q    <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_load_q <= 1'b0;
      mac_ce_q   <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      for (int i = 0; i < int'(NTAPS); i++) begin
        delay_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            delay_q[wptr_q] <= s_data;
            k_q             <= '0;
          end
        end
        StRun: begin
          mac_a_q    <= delay_q[rd_idx];
          mac_b_q    <= coef_q[k_q];
          mac_load_q <= (k_q == '0);
          mac_ce_q   <= 1'b1;
          k_q        <= k_q + 1'b1;
          drain_q    <= '0;
        end
        StDrain: begin
          // Keep the MAC clocked so the last pair lands; zero operands add nothing.
          mac_a_q    <= '0;
          mac_b_q    <= '0;
          mac_load_q <= 1'b0;
          mac_ce_q   <= 1'b1;
          drain_q    <= drain_q + 1'b1;
          if (drain_q == DW'(MAC_LAT)) begin
            m_data_q  <= quant;
            m_valid_q <= 1'b1;
            wptr_q    <= wptr_q + 1'b1;
            mac_ce_q  <= 1'b0;
          end
        end
        StOut: begin
          mac_ce_q <= 1'b0;
          if (m_ready) m_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Coefficients are deliberately unreset; they are only writable while idle.
  always_ff @(posedge clk) begin
    if (coef_wr_en && !busy) begin
      coef_q[coef_wr_addr] <= coef_wr_data;
    end
  end

endmodule
